// File: rtl/delay_pkg.sv
// Shared types and defaults for the multi-channel delay/tick generator.
package delay_pkg;

   typedef enum logic {IDLE, RUN} chan_state_e;
   typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} delay_mode_e;

   localparam int DEF_PERIOD_C = 400000;

endpackage

// File: rtl/delay_chan.sv
// One delay channel: IDLE/RUN FSM, expiry counter, period/mode registers, sticky err.
module delay_chan
   import delay_pkg::*;
#(
   parameter int CBITS      = 19,
   parameter int DEF_PERIOD = DEF_PERIOD_C
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [CBITS-1:0] cfg_period,
   input  logic             cfg_mode,
   input  logic             start,
   input  logic             stop,
   input  logic             sync,
   output logic             sig,
   output logic             flg,
   output logic             err,
   output logic             run
);

   chan_state_e      state_q, state_d;
   delay_mode_e      mode_q, mode_d;
   logic [CBITS-1:0] cnt_q, cnt_d;
   logic [CBITS-1:0] period_q, period_d;
   logic             sig_q, sig_d;
   logic             err_q, err_d;
   logic             expire;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         mode_q   <= MODE_PERIODIC;
         cnt_q    <= '0;
         period_q <= CBITS'(DEF_PERIOD);
         sig_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         sig_q    <= sig_d;
         err_q    <= err_d;
      end
   end

   assign expire = (cnt_q == period_q - CBITS'(1));

   // NOTE: every variable gets a default first so the combinational block cannot infer a latch.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      sig_d    = 1'b0;
      err_d    = err_q;

      // Config lands before start, so a same-cycle start already uses the new period/mode.
      if (cfg_we) begin
         if (cfg_period == '0) begin
            err_d = 1'b1;
         end else begin
            period_d = cfg_period;
            mode_d   = delay_mode_e'(cfg_mode);
         end
      end

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (start) begin
               cnt_d = '0;
               err_d = 1'b1;
            end else if (sync) begin
               cnt_d = '0;
            end else if (expire) begin
               sig_d = 1'b1;
               cnt_d = '0;
               if (mode_q == MODE_ONESHOT) state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CBITS'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      run = (state_q == RUN);
      flg = run && (cnt_q < period_q);
      sig = sig_q;
      err = err_q;
   end

endmodule

// File: rtl/delay_multi.sv
// Multi-channel programmable delay/tick generator: cfg decode, cfg_ready mux, busy reduction.
// Optional DELAY_SYNC_EN adds a `sync` input that phase-aligns all running channels.
module delay_multi
   import delay_pkg::*;
#(
   parameter  int NCH        = 4,
   parameter  int CBITS      = 19,
   parameter  int DEF_PERIOD = DEF_PERIOD_C,
   localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CBITS-1:0] cfg_period,
   input  logic             cfg_mode,
   input  logic [NCH-1:0]   start,
   input  logic [NCH-1:0]   stop,
`ifdef DELAY_SYNC_EN
   input  logic             sync,
`endif
   output logic [NCH-1:0]   sig,
   output logic [NCH-1:0]   flg,
   output logic [NCH-1:0]   err,
   output logic             busy
);

   logic [NCH-1:0] run;
   logic           ch_valid;
   logic           cfg_xfer;
   logic           sync_w;

`ifdef DELAY_SYNC_EN
   assign sync_w = sync;
`else
   assign sync_w = 1'b0;
`endif

   // Out-of-range channels always accept so a bad address cannot stall the requester.
   assign ch_valid  = int'(cfg_ch) < NCH;
   assign cfg_ready = !ch_valid || !run[cfg_ch];
   assign cfg_xfer  = cfg_valid && cfg_ready;
   assign busy      = |run;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      delay_chan #(
         .CBITS      (CBITS),
         .DEF_PERIOD (DEF_PERIOD)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .cfg_we     (cfg_xfer && (int'(cfg_ch) == gi)),
         .cfg_period (cfg_period),
         .cfg_mode   (cfg_mode),
         .start      (start[gi]),
         .stop       (stop[gi]),
         .sync       (sync_w),
         .sig        (sig[gi]),
         .flg        (flg[gi]),
         .err        (err[gi]),
         .run        (run[gi])
      );
   end

endmodule

// File: tb/tb_delay_multi.sv
// Scoreboard bench for delay_multi: an absolute-time expiry model predicts pulses and status.
module tb_delay_multi;

   localparam int NCH   = 5;
   localparam int CBITS = 19;
   localparam int DEFP  = 200;
   localparam int CH_W  = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch = '0;
   logic [CBITS-1:0] cfg_period = '0;
   logic             cfg_mode = 1'b0;
   logic [NCH-1:0]   start = '0;
   logic [NCH-1:0]   stop = '0;
   logic             sync = 1'b0;
   logic [NCH-1:0]   sig, flg, err;
   logic             busy;

   delay_multi #(.NCH(NCH), .CBITS(CBITS), .DEF_PERIOD(DEFP)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .cfg_mode   (cfg_mode),
      .start      (start),
      .stop       (stop),
`ifdef DELAY_SYNC_EN
      .sync       (sync),
`endif
      .sig        (sig),
      .flg        (flg),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: each running channel knows the absolute cycle of its next expiry.
   bit m_run [NCH];
   int m_due [NCH];
   int m_per [NCH];
   bit m_one [NCH];
   bit m_err [NCH];
   int exp_q [NCH][$];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc = 0;
         for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_due[i] = 0; m_per[i] = DEFP; m_one[i] = 0; m_err[i] = 0;
            exp_q[i].delete();
         end
      end else begin
         bit acc;
         cyc++;
         acc = cfg_valid && ((cfg_ch >= NCH) || !m_run[cfg_ch]);
         if (acc && cfg_ch < NCH) begin
            if (cfg_period == 0) m_err[cfg_ch] = 1;
            else begin
               m_per[cfg_ch] = int'(cfg_period);
               m_one[cfg_ch] = cfg_mode;
            end
         end
         for (int i = 0; i < NCH; i++) begin
            if (m_run[i]) begin
               if (stop[i]) m_run[i] = 0;
               else if (start[i]) begin
                  m_err[i] = 1;
                  m_due[i] = cyc + m_per[i];
               end else if (sync) m_due[i] = cyc + m_per[i];
               else if (m_due[i] == cyc) begin
                  exp_q[i].push_back(cyc);
                  if (m_one[i]) m_run[i] = 0;
                  else m_due[i] = cyc + m_per[i];
               end
            end else if (start[i] && !stop[i]) begin
               m_run[i] = 1;
               m_due[i] = cyc + m_per[i];
            end
         end
      end
   end

   // Monitor: pops an expected pulse whenever the DUT shows one, and checks status outputs.
   always @(negedge clk) begin
      if (rst) begin
         logic [NCH-1:0] ef, ee;
         for (int i = 0; i < NCH; i++) begin
            ef[i] = m_run[i];
            ee[i] = m_err[i];
            if (sig[i]) begin
               if (exp_q[i].size() == 0) check($sformatf("sig%0d_unexpected", i), 32'(sig[i]), 0);
               else check($sformatf("sig%0d_cycle", i), cyc, exp_q[i].pop_front());
            end else if (exp_q[i].size() != 0) begin
               check($sformatf("sig%0d_missing", i), 32'(sig[i]), 1);
               exp_q[i].delete();
            end
         end
         check("flg", 32'(flg), 32'(ef));
         check("err", 32'(err), 32'(ee));
         check("busy", 32'(busy), 32'(|ef));
         check("cfg_ready", 32'(cfg_ready), 32'((cfg_ch >= NCH) || !m_run[cfg_ch]));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_cfg(input int ch, input int p, input bit m);
      cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_period = CBITS'(p); cfg_mode = m;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic pulse(input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
      start = st; stop = sp;
      tick();
      start = '0; stop = '0;
   endtask

   initial begin
      #12;
      check("rst_sig", 32'(sig), 0);
      check("rst_flg", 32'(flg), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ready", 32'(cfg_ready), 1);
      @(posedge clk); #1 rst = 1'b1;
      tick();

      // Default period: two pulses in 2P+1 cycles.
      pulse(5'b00001, '0);
      tick(2 * DEFP + 1);
      pulse('0, 5'b00001);

      // Periodic P=4 with a stop between the 2nd and 3rd pulse.
      do_cfg(1, 4, 0);
      pulse(5'b00010, '0);
      tick(8);
      pulse('0, 5'b00010);
      tick(6);

      // One-shot P=3; cfg_ch parked on ch2 so cfg_ready tracks its RUN state.
      do_cfg(2, 3, 1);
      cfg_ch = 3'd2;
      pulse(5'b00100, '0);
      tick(6);

      // Zero period is rejected with a sticky error; ch3 then runs at the default period.
      do_cfg(3, 0, 0);
      check("err3_set", 32'(err[3]), 1);
      pulse(5'b01000, '0);
      tick(DEFP + 2);
      pulse('0, 5'b01000);

      // Re-arm: second start sets err and restarts the interval.
      do_cfg(0, 6, 0);
      pulse(5'b00001, '0);
      tick(1);
      pulse(5'b00001, '0);
      tick(9);
      pulse('0, 5'b00001);

      // Out-of-range channel is accepted and ignored.
      do_cfg(6, 0, 1);
      tick(2);

      // start+stop together keeps the channel idle.
      pulse(5'b00010, 5'b00010);
      tick(3);
      check("ss_idle", 32'(flg[1]), 0);

`ifdef DELAY_SYNC_EN
      do_cfg(0, 5, 0);
      do_cfg(1, 7, 0);
      pulse(5'b00011, '0);
      tick(2);
      sync = 1'b1;
      tick();
      sync = 1'b0;
      tick(12);
      pulse('0, 5'b00011);
`endif

      // Reset mid-run at cnt=2.
      do_cfg(1, 4, 0);
      pulse(5'b00010, '0);
      tick(2);
      rst = 1'b0;
      #1;
      check("mrst_sig", 32'(sig), 0);
      check("mrst_flg", 32'(flg), 0);
      check("mrst_err", 32'(err), 0);
      check("mrst_busy", 32'(busy), 0);
      check("mrst_ready", 32'(cfg_ready), 1);
      tick();
      rst = 1'b1;
      tick();
      pulse(5'b00010, '0);
      tick(DEFP + 2);
      pulse('0, 5'b00010);

      // Randomised traffic with short periods.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NCH; i++) begin
            start[i] = ($urandom_range(0, 11) == 0);
            stop[i]  = ($urandom_range(0, 24) == 0);
         end
         cfg_valid  = ($urandom_range(0, 3) == 0);
         cfg_ch     = CH_W'($urandom_range(0, 7));
         cfg_period = CBITS'($urandom_range(0, 12));
         cfg_mode   = $urandom_range(0, 1);
`ifdef DELAY_SYNC_EN
         sync = ($urandom_range(0, 29) == 0);
`endif
         tick();
      end
      start = '0; stop = '0; cfg_valid = 1'b0; sync = 1'b0;
      tick(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
